frame_phase_ctrl: RTL
=====================

# frame_phase_ctrl

Parametrised frame sequencer for the streaming line-buffer filter path. It counts accepted input pixels and sequences each frame through the FILL, RUN, DRAIN and LAST phases, gating input during the flush. It counts accepted output beats to generate per-line `output_eol` and per-frame `output_last`, and re-arms automatically for the next frame. It sits between the stream input and the window/line-buffer datapath, which consumes `state` to enable buffering and emitting.

## Interface
- `IMG_W`, 1024: pixels per line (≥2).
- `IMG_H`, 1024: lines per frame (≥2).
- `PRE_PIX`, IMG_W+2: accepted pixels before the window is valid (1 ≤ PRE_PIX < IMG_W·IMG_H).
- `DRAIN`, 6: datapath pipeline depth to flush after the last input pixel (≥1).
- `clk`  in  1  clock; everything on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `soft_clr`  in  1  synchronous frame abort; returns the block to the reset state.
- `in_en`  in  1  input pixel offered; accepted only when `in_en & input_ready`.
- `input_last`  in  1  upstream end-of-frame marker, qualified by acceptance.
- `input_ready`  out  1  block accepts pixels; high in FILL and RUN.
- `output_valid`  in  1  datapath output beat valid.
- `output_ready`  in  1  downstream ready.
- `state`  out  4  registered one-hot phase: 0001 FILL, 0010 RUN, 0100 DRAIN, 1000 LAST.
- `output_last`  out  1  current output beat is the frame's final beat.
- `output_eol`  out  1  current output beat ends a line.
- `frame_done`  out  1  one-cycle pulse after the final output handshake.
- `err_last`  out  1  sticky flag: `input_last` was mis-positioned.

## Operation
- Definitions:
  - TOTAL = IMG_W·IMG_H.
  - `acc` = `in_en & input_ready`.
  - `ofire` = `output_valid & output_ready`.
- `in_cnt` (width $clog2(TOTAL+1)) increments on `acc`.
- FILL → RUN on the `acc` that makes `in_cnt` = PRE_PIX.
- RUN → DRAIN on the `acc` that makes `in_cnt` = TOTAL. `input_ready` is low from the next cycle.
- DRAIN: `drn_cnt` increments only on cycles with `output_ready` high, so the flush is stall-aware. DRAIN → LAST on the increment that makes `drn_cnt` = DRAIN.
- LAST waits for `ofire & output_last`. It then pulses `frame_done` for one cycle, clears all counters and returns to FILL.
- Output side:
  - `col_cnt` (0..IMG_W-1) and `row_cnt` (0..IMG_H-1) advance on `ofire` in any state, wrapping the column into the row.
  - `output_eol` = (`col_cnt` = IMG_W-1).
  - `output_last` = `output_eol` & (`row_cnt` = IMG_H-1).
  - Both are decoded from registers only; no combinational path from the inputs.
- `err_last` sets on:
  - an `acc` with `input_last` high while `in_cnt` ≠ TOTAL-1; or
  - an `acc` at `in_cnt` = TOTAL-1 with `input_last` low.
  The frame length is fixed by parameters, so `err_last` never alters sequencing. It clears only on `soft_clr` or reset.
- Priority: reset > `soft_clr` > normal update.
- `ofire` beyond the final beat (after the row/column wrap) is not possible in a legal flow. If it occurs, the output counters wrap normally.

## Timing
- Reset values:
  - `state` = 0001, `input_ready` = 1, `output_last` = 0, `output_eol` = 0 (IMG_W ≥ 2), `frame_done` = 0, `err_last` = 0.
  - All counters 0.
- `state` changes on the clock edge after the triggering `acc` or `ready`. There are no combinational phase outputs.
- `input_ready` is low in DRAIN and LAST. An `in_en` offered there is ignored and does not count.
- `frame_done` is high exactly in the cycle after the final `ofire`, in which `state` = 0001 again. An `acc` in that cycle counts toward the new frame.
- Reset or `soft_clr` mid-frame: all counters clear and `state` = FILL on the next edge. No `frame_done` or `output_last` is produced for the aborted frame.

## Structure
- Shared package `fpc_pkg`:
  - phase one-hot constants `PH_FILL`, `PH_RUN`, `PH_DRAIN`, `PH_LAST`;
  - the `$clog2` width helper.
- One natural sub-module, `beat_pos_cnt`: the column/row counter with EOL/last decode. It is reusable on the input side in later revisions.

## Test plan
All scenarios use IMG_W=4, IMG_H=3, PRE_PIX=6, DRAIN=2.
- Reset, then 12 back-to-back `acc` → `state`:
  - 0001 for cycles 0–5;
  - 0010 after the 6th pixel;
  - 0100 after the 12th pixel, with `input_ready` low from the next cycle.
- DRAIN with `output_ready` pattern 1,0,1 → LAST entered only after the second ready cycle.
- 12 `ofire` beats:
  - `output_eol` high on beats 4, 8 and 12;
  - `output_last` high on beat 12 only;
  - `frame_done` pulses once, the next cycle `state` = 0001, and a second frame runs identically.
- `input_last` asserted on pixel 7 → `err_last` = 1 and stays 1 through frame end. Phases are unchanged; `soft_clr` clears it.
- `in_en` held high during DRAIN/LAST → `in_cnt` unchanged.
- `rst_n` low mid-RUN (`in_cnt` = 8) → outputs at reset values immediately; restart counts from 0.

Source files
------------

// File: rtl/fpc_pkg.sv
// Shared definitions for the frame phase sequencer: one-hot phase encoding
// and the counter width helper.
package fpc_pkg;

  // One-hot frame phases; the datapath consumes these bits directly.
  typedef enum logic [3:0] {
    PH_FILL  = 4'b0001,
    PH_RUN   = 4'b0010,
    PH_DRAIN = 4'b0100,
    PH_LAST  = 4'b1000
  } phase_e;

  // Bits needed to hold every value 0..max_val (never less than one bit).
  function automatic int cnt_w(input int max_val);
    if (max_val < 1) begin
      return 1;
    end else begin
      return $clog2(max_val + 1);
    end
  endfunction

endpackage

// File: rtl/beat_pos_cnt.sv
// Column/row position counter for a stream of beats with registered
// end-of-line and end-of-frame flags for the beat currently presented.
module beat_pos_cnt
  import fpc_pkg::*;
#(
  parameter int IMG_W = 1024,
  parameter int IMG_H = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic adv,
  output logic eol,
  output logic last
);
  localparam int COL_W = cnt_w(IMG_W - 1);
  localparam int ROW_W = cnt_w(IMG_H - 1);
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(IMG_H - 1);

  logic [COL_W-1:0] col_r, col_nxt_s;
  logic [ROW_W-1:0] row_r, row_nxt_s;
  logic             eol_r, last_r;

  // Next position: the column wraps into the row, the row wraps to zero.
  always_comb begin
    col_nxt_s = col_r;
    row_nxt_s = row_r;
    if (col_r == COL_MAX) begin
      col_nxt_s = {COL_W{1'b0}};
      if (row_r == ROW_MAX) begin
        row_nxt_s = {ROW_W{1'b0}};
      end else begin
        row_nxt_s = row_r + ROW_W'(1);
      end
    end else begin
      col_nxt_s = col_r + COL_W'(1);
      row_nxt_s = row_r;
    end
  end

  // Position registers; flags are precomputed so the outputs are pure flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_r  <= {COL_W{1'b0}};
      row_r  <= {ROW_W{1'b0}};
      eol_r  <= 1'b0;
      last_r <= 1'b0;
    end else if (clr) begin
      col_r  <= {COL_W{1'b0}};
      row_r  <= {ROW_W{1'b0}};
      eol_r  <= 1'b0;
      last_r <= 1'b0;
    end else if (adv) begin
      col_r  <= col_nxt_s;
      row_r  <= row_nxt_s;
      eol_r  <= (col_nxt_s == COL_MAX);
      last_r <= (col_nxt_s == COL_MAX) && (row_nxt_s == ROW_MAX);
    end else begin
      col_r  <= col_r;
      row_r  <= row_r;
      eol_r  <= eol_r;
      last_r <= last_r;
    end
  end

  assign eol  = eol_r;
  assign last = last_r;

endmodule

// File: rtl/frame_phase_ctrl.sv
// Frame sequencer: counts accepted pixels through FILL/RUN, flushes the
// datapath in DRAIN, waits for the final output beat in LAST, then re-arms.
module frame_phase_ctrl
  import fpc_pkg::*;
#(
  parameter int IMG_W   = 1024,
  parameter int IMG_H   = 1024,
  parameter int PRE_PIX = IMG_W + 2,
  parameter int DRAIN   = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       soft_clr,
  input  logic       in_en,
  input  logic       input_last,
  output logic       input_ready,
  input  logic       output_valid,
  input  logic       output_ready,
  output logic [3:0] state,
  output logic       output_last,
  output logic       output_eol,
  output logic       frame_done,
  output logic       err_last
);
  localparam int TOTAL = IMG_W * IMG_H;
  localparam int IN_W  = cnt_w(TOTAL);
  localparam int DRN_W = cnt_w(DRAIN);
  localparam logic [IN_W-1:0]  PRE_C      = IN_W'(PRE_PIX);
  localparam logic [IN_W-1:0]  TOTAL_C    = IN_W'(TOTAL);
  localparam logic [IN_W-1:0]  LAST_IDX_C = IN_W'(TOTAL - 1);
  localparam logic [DRN_W-1:0] DRAIN_C    = DRN_W'(DRAIN);

  phase_e           state_r, state_nxt_s;
  logic             input_ready_r, frame_done_r, err_last_r;
  logic [IN_W-1:0]  in_cnt_r, in_cnt_inc_s;
  logic [DRN_W-1:0] drn_cnt_r, drn_cnt_inc_s;
  logic             acc_s, ofire_s, frame_end_s, out_clr_s;
  logic             out_eol_s, out_last_s;

  assign acc_s         = in_en & input_ready_r;
  assign ofire_s       = output_valid & output_ready;
  assign in_cnt_inc_s  = in_cnt_r + IN_W'(1);
  assign drn_cnt_inc_s = drn_cnt_r + DRN_W'(1);
  assign frame_end_s   = (state_r == PH_LAST) && ofire_s && out_last_s;
  assign out_clr_s     = soft_clr | frame_end_s;

  // Phase transition decode from the current phase and this cycle's events.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      PH_FILL: begin
        if (acc_s && (in_cnt_inc_s == PRE_C)) begin
          state_nxt_s = PH_RUN;
        end else begin
          state_nxt_s = PH_FILL;
        end
      end
      PH_RUN: begin
        if (acc_s && (in_cnt_inc_s == TOTAL_C)) begin
          state_nxt_s = PH_DRAIN;
        end else begin
          state_nxt_s = PH_RUN;
        end
      end
      PH_DRAIN: begin
        // Only cycles where downstream can move count toward the flush.
        if (output_ready && (drn_cnt_inc_s == DRAIN_C)) begin
          state_nxt_s = PH_LAST;
        end else begin
          state_nxt_s = PH_DRAIN;
        end
      end
      PH_LAST: begin
        if (frame_end_s) begin
          state_nxt_s = PH_FILL;
        end else begin
          state_nxt_s = PH_LAST;
        end
      end
      default: state_nxt_s = PH_FILL;
    endcase
  end

  // Phase register with its registered outputs (ready, done pulse).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= PH_FILL;
      input_ready_r <= 1'b1;
      frame_done_r  <= 1'b0;
    end else if (soft_clr) begin
      state_r       <= PH_FILL;
      input_ready_r <= 1'b1;
      frame_done_r  <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      input_ready_r <= (state_nxt_s == PH_FILL) || (state_nxt_s == PH_RUN);
      frame_done_r  <= frame_end_s;
    end
  end

  // Input pixel and drain counters; both re-arm after the final beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_cnt_r  <= {IN_W{1'b0}};
      drn_cnt_r <= {DRN_W{1'b0}};
    end else if (out_clr_s) begin
      in_cnt_r  <= {IN_W{1'b0}};
      drn_cnt_r <= {DRN_W{1'b0}};
    end else begin
      if (acc_s) begin
        in_cnt_r <= in_cnt_inc_s;
      end else begin
        in_cnt_r <= in_cnt_r;
      end
      if ((state_r == PH_DRAIN) && output_ready) begin
        drn_cnt_r <= drn_cnt_inc_s;
      end else begin
        drn_cnt_r <= drn_cnt_r;
      end
    end
  end

  // Sticky marker check: input_last must coincide exactly with the final pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_last_r <= 1'b0;
    end else if (soft_clr) begin
      err_last_r <= 1'b0;
    end else if (acc_s && (input_last != (in_cnt_r == LAST_IDX_C))) begin
      err_last_r <= 1'b1;
    end else begin
      err_last_r <= err_last_r;
    end
  end

  beat_pos_cnt #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H)
  ) u_out_pos (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (out_clr_s),
    .adv   (ofire_s),
    .eol   (out_eol_s),
    .last  (out_last_s)
  );

  assign state       = state_r;
  assign input_ready = input_ready_r;
  assign frame_done  = frame_done_r;
  assign err_last    = err_last_r;
  assign output_eol  = out_eol_s;
  assign output_last = out_last_s;

endmodule
